// File: rtl/mips_pkg.sv
// Shared types and constants for the multicycle MIPS control path.
package mips_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    ADDR   = 3'd4,
    MEM    = 3'd5
  } fsm_state_t;

  localparam fsm_state_t FSM_RESET_STATE = FETCH;

endpackage

// File: rtl/mips_cycle_fsm.sv
// Multicycle phase sequencer: FETCH -> DECODE -> EXEC -> ADDR -> MEM, stalling in MEM on
// WaitRequest. State is a pure register output with no combinational path from the inputs.
module mips_cycle_fsm
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       WaitRequest,
  output logic [2:0] State
);

  fsm_state_t r_state;
  fsm_state_t w_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= FSM_RESET_STATE;
    end else begin
      r_state <= w_next;
    end
  end

  // Codes 0, 6 and 7 are reachable only through upsets; the default arm recovers to FETCH.
  always_comb begin
    w_next = FETCH;
    case (r_state)
      FETCH:   w_next = DECODE;
      DECODE:  w_next = EXEC;
      EXEC:    w_next = ADDR;
      ADDR:    w_next = MEM;
      MEM:     w_next = WaitRequest ? MEM : FETCH;
      default: w_next = FETCH;
    endcase
  end

  assign State = 3'(r_state);

endmodule

// File: tb/tb_mips_cycle_fsm.sv
// Directed-vector bench for mips_cycle_fsm; each vector drives reset/WaitRequest for one edge
// and gives the State expected just after that edge.
module tb_mips_cycle_fsm;

  logic       clk;
  logic       reset;
  logic       WaitRequest;
  logic [2:0] State;

  int unsigned checks;
  int unsigned errors;

  mips_cycle_fsm dut (
    .clk         (clk),
    .reset       (reset),
    .WaitRequest (WaitRequest),
    .State       (State)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: State got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Packed {reset, WaitRequest, expected State}.
  localparam int NumVec = 33;
  logic [4:0] vec [NumVec];

  initial begin
    vec = '{
      // reset then free run
      5'b10_001,
      5'b00_010, 5'b00_011, 5'b00_100, 5'b00_101, 5'b00_001, 5'b00_010,
      // reach MEM, stall three edges, then leave
      5'b00_011, 5'b00_100, 5'b00_101,
      5'b01_101, 5'b01_101, 5'b01_101,
      5'b00_001,
      // WaitRequest high outside MEM has no effect
      5'b01_010, 5'b01_011, 5'b01_100, 5'b01_101,
      5'b00_001,
      // reset taken while in EXEC
      5'b00_010, 5'b00_011,
      5'b10_001, 5'b00_010,
      // reset wins over a MEM stall
      5'b00_011, 5'b00_100, 5'b00_101,
      5'b11_001, 5'b00_010,
      // reset held four edges
      5'b10_001, 5'b10_001, 5'b10_001, 5'b10_001,
      5'b00_010
    };
  end

  initial begin
    checks      = 0;
    errors      = 0;
    reset       = 1'b1;
    WaitRequest = 1'b0;
    #1;
    for (int i = 0; i < NumVec; i++) begin
      reset       = vec[i][4];
      WaitRequest = vec[i][3];
      @(posedge clk);
      #1;
      check_eq($sformatf("vec%0d", i), State, vec[i][2:0]);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
